// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master Wishbone classic round-robin arbiter with stalled-strobe watchdog
module wb_rr_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int unsigned TIMEOUT = 255,
    localparam int SW = DW / 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [SW-1:0] m0_sel_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [SW-1:0] m1_sel_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [SW-1:0] s_sel_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    output logic [1:0]    grant_o,
    output logic          timeout_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, last_q, last_d;
    logic [15:0] wdog_q, wdog_d;
    logic busy, o_cyc, o_stb, stall, wdog_fire;
    assign busy = state_q == BUSY;
    assign o_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    assign o_stb = owner_q ? m1_stb_i : m0_stb_i;
    // a slave termination in the limit cycle wins over the watchdog
    assign stall = TIMEOUT != 0 && busy && o_stb && !(s_ack_i || s_err_i);
    assign wdog_fire = stall && wdog_q == 16'(TIMEOUT);
    assign s_cyc_o = busy && o_cyc;
    assign s_stb_o = busy && o_stb && !wdog_fire;
    assign s_we_o = busy && (owner_q ? m1_we_i : m0_we_i);
    assign s_adr_o = !busy ? '0 : owner_q ? m1_adr_i : m0_adr_i;
    assign s_dat_o = !busy ? '0 : owner_q ? m1_dat_i : m0_dat_i;
    assign s_sel_o = !busy ? '0 : owner_q ? m1_sel_i : m0_sel_i;
    assign grant_o = busy ? {owner_q, !owner_q} : 2'b00;
    assign m0_ack_o = grant_o[0] && s_ack_i;
    assign m1_ack_o = grant_o[1] && s_ack_i;
    assign m0_err_o = grant_o[0] && (s_err_i || wdog_fire);
    assign m1_err_o = grant_o[1] && (s_err_i || wdog_fire);
    assign m0_dat_o = busy ? s_dat_i : '0;
    assign m1_dat_o = busy ? s_dat_i : '0;
    assign timeout_o = wdog_fire;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        wdog_d = '0;
        if (!busy) begin
            if (m0_cyc_i || m1_cyc_i) begin
                state_d = BUSY;
                owner_d = (m0_cyc_i && m1_cyc_i) ? !last_q : m1_cyc_i;
            end
        end else if (!o_cyc) begin
            state_d = IDLE;
            last_d = owner_q;
        end else if (stall && !wdog_fire) begin
            wdog_d = wdog_q + 16'd1;
        end
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q <= 1'b1;
            wdog_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            wdog_q <= wdog_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed vector table plus write-path and async-reset sequences
module tb_wb_rr_arbiter;
    localparam int AW = 32, DW = 32, SW = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_wd, m1_wd, m0_rd, m1_rd, s_wd, s_rd;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic s_cyc, s_stb, s_we, s_ack, s_err, timeout;
    logic [1:0] grant;
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_wd), .m0_sel_i(m0_sel), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_wd), .m1_sel_i(m1_sel), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wd),
        .s_sel_o(s_sel), .s_dat_i(s_rd), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant), .timeout_o(timeout)
    );
    typedef struct {
        logic [5:0] in;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[$];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [8:0] outs();
        return {s_cyc, s_stb, grant, m0_ack, m1_ack, m0_err, m1_err, timeout};
    endfunction
    task automatic drive(input logic [5:0] v);
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = v;
    endtask
    initial begin
        // in = {m0_cyc,m0_stb,m1_cyc,m1_stb,s_ack,s_err}
        // exp = {s_cyc,s_stb,grant[1:0],m0_ack,m1_ack,m0_err,m1_err,timeout}
        vecs.push_back('{6'b000000, 9'b0_0_00_00000});
        vecs.push_back('{6'b001100, 9'b0_0_00_00000});
        vecs.push_back('{6'b001100, 9'b1_1_10_00000});
        vecs.push_back('{6'b001100, 9'b1_1_10_00000});
        vecs.push_back('{6'b001110, 9'b1_1_10_01000});
        vecs.push_back('{6'b000000, 9'b0_0_10_00000});
        vecs.push_back('{6'b000000, 9'b0_0_00_00000});
        vecs.push_back('{6'b111100, 9'b0_0_00_00000});
        vecs.push_back('{6'b111110, 9'b1_1_01_10000});
        vecs.push_back('{6'b001100, 9'b0_0_01_00000});
        vecs.push_back('{6'b001100, 9'b0_0_00_00000});
        vecs.push_back('{6'b111110, 9'b1_1_10_01000});
        vecs.push_back('{6'b000000, 9'b0_0_10_00000});
        vecs.push_back('{6'b111100, 9'b0_0_00_00000});
        vecs.push_back('{6'b111110, 9'b1_1_01_10000});
        vecs.push_back('{6'b000000, 9'b0_0_01_00000});
        vecs.push_back('{6'b110000, 9'b0_0_00_00000});
        vecs.push_back('{6'b111110, 9'b1_1_01_10000});
        vecs.push_back('{6'b101100, 9'b1_0_01_00000});
        vecs.push_back('{6'b111110, 9'b1_1_01_10000});
        vecs.push_back('{6'b111110, 9'b1_1_01_10000});
        vecs.push_back('{6'b001100, 9'b0_0_01_00000});
        vecs.push_back('{6'b001100, 9'b0_0_00_00000});
        vecs.push_back('{6'b001110, 9'b1_1_10_01000});
        vecs.push_back('{6'b000000, 9'b0_0_10_00000});
        vecs.push_back('{6'b110000, 9'b0_0_00_00000});
        for (int i = 0; i < 4; i++) vecs.push_back('{6'b110000, 9'b1_1_01_00000});
        vecs.push_back('{6'b110000, 9'b1_0_01_00101});
        vecs.push_back('{6'b000000, 9'b0_0_01_00000});
        vecs.push_back('{6'b110000, 9'b0_0_00_00000});
        vecs.push_back('{6'b110010, 9'b1_1_01_10000});
        vecs.push_back('{6'b000000, 9'b0_0_01_00000});
        vecs.push_back('{6'b110000, 9'b0_0_00_00000});
        for (int i = 0; i < 4; i++) vecs.push_back('{6'b110000, 9'b1_1_01_00000});
        vecs.push_back('{6'b110010, 9'b1_1_01_10000});
        vecs.push_back('{6'b110000, 9'b1_1_01_00000});
        vecs.push_back('{6'b000000, 9'b0_0_01_00000});
        vecs.push_back('{6'b000000, 9'b0_0_00_00000});
        vecs.push_back('{6'b001100, 9'b0_0_00_00000});
        vecs.push_back('{6'b001101, 9'b1_1_10_00010});
        vecs.push_back('{6'b000010, 9'b0_0_10_01000});
        vecs.push_back('{6'b000000, 9'b0_0_00_00000});
        drive(6'b000000);
        m0_we = 1'b0; m0_adr = 32'h0000_0100; m0_wd = 32'h0; m0_sel = 4'hF;
        m1_we = 1'b0; m1_adr = 32'h0000_0010; m1_wd = 32'h0; m1_sel = 4'hF;
        s_rd = 32'hDEAD_BEEF;
        #2 chk("reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in);
            #1 chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
            if (vecs[i].exp[3]) chk($sformatf("vec%0d_m1_dat", i), 64'(m1_rd), 64'hDEAD_BEEF);
        end
        // write path from m0
        @(negedge clk);
        m0_we = 1'b1; m0_adr = 32'h0001_0004; m0_wd = 32'h1234_5678; m0_sel = 4'b0011;
        drive(6'b110000);
        #1 chk("wr_idle_grant", 64'(grant), 64'd0);
        @(negedge clk);
        #1 chk("wr_grant", 64'(grant), 64'd1);
        chk("wr_we", 64'(s_we), 64'd1);
        chk("wr_adr", 64'(s_adr), 64'h0001_0004);
        chk("wr_dat", 64'(s_wd), 64'h1234_5678);
        chk("wr_sel", 64'(s_sel), 64'h3);
        @(negedge clk);
        drive(6'b110010);
        #1 chk("wr_ack", 64'({m0_ack, m1_ack}), 64'b10);
        chk("wr_m0_rd", 64'(m0_rd), 64'hDEAD_BEEF);
        @(negedge clk);
        drive(6'b000000);
        m0_we = 1'b0;
        // async reset while m1 owns the bus
        @(negedge clk);
        drive(6'b001100);
        @(negedge clk);
        #1 chk("ar_grant", 64'({s_cyc, grant}), 64'b1_10);
        chk("ar_adr", 64'(s_adr), 64'h10);
        s_ack = 1'b1;
        #1 chk("ar_ack", 64'(m1_ack), 64'd1);
        #1 rst = 1'b1;
        #1 chk("ar_cleared", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(6'b111100);
        @(negedge clk);
        #1 chk("ar_tie_m0", 64'({s_cyc, grant}), 64'b1_01);
        @(negedge clk);
        drive(6'b000000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master to one-slave Wishbone classic arbiter with round-robin fairness and a bus-hang watchdog. It shares a single slave bus between the SCR1 instruction and data master ports, for example in front of a single `wb_ram` on a reduced SoC without the full crossbar. It holds each grant for a whole `cyc` and terminates stalled strobes with `err`.

## Interface
Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width. `SW = DW/8` select lanes.
- `TIMEOUT`, default 255: stalled-strobe limit in cycles. 0 disables the watchdog. Range 0..65535; the counter is 16 bits.

Ports:
- `wb_clk_i`  in  1  clock; all logic on the rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 (instruction) cycle, strobe, write enable.
- `m0_adr_i`  in  AW  master 0 address.
- `m0_dat_i`  in  DW  master 0 write data.
- `m0_sel_i`  in  SW  master 0 byte select.
- `m0_dat_o`  out  DW  master 0 read data.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 termination.
- `m1_*`  same set as `m0_*`  master 1 (data).
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave cycle, strobe, write enable.
- `s_adr_o`  out  AW  slave address.
- `s_dat_o`  out  DW  slave write data.
- `s_sel_o`  out  SW  slave byte select.
- `s_dat_i`  in  DW  slave read data.
- `s_ack_i`, `s_err_i`  in  1 each  slave termination.
- `grant_o`  out  2  one-hot current owner; `00` when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Registered state: `state` (IDLE or BUSY), `owner` (1 bit), `last` (1 bit, last-served master), `wdog` (16-bit counter).
- IDLE:
  - All `s_*` control outputs are 0 and `grant_o = 00`.
  - If exactly one `mX_cyc_i` is high, that master becomes owner. The next state is BUSY.
  - If both are high, the owner is `~last`.
- BUSY:
  - `s_cyc_o/stb/we/adr/dat/sel` mirror the owner combinationally.
  - `s_stb_o` is additionally gated low while the watchdog fires.
  - Owner receives `ack = s_ack_i` and `err = s_err_i | wdog_fire`.
  - The non-owner's `ack` and `err` are forced to 0.
  - Both masters' `dat_o = s_dat_i`.
- Release: when the owner's `cyc_i` is low at a clock edge, the state goes to IDLE and `last <= owner`.
  - The grant is held across multiple strobes while `cyc` stays high. There is no pre-emption.
- Watchdog (TIMEOUT > 0):
  - `wdog` increments each BUSY cycle with owner `stb` high and `s_ack_i | s_err_i` low. It clears otherwise.
  - `wdog_fire` is high when `wdog == TIMEOUT` and the owner's `stb` is high. That cycle:
    - the owner sees `err = 1`;
    - `s_stb_o = 0`;
    - `timeout_o = 1`;
    - `wdog` clears.
- If TIMEOUT = 0, `wdog` stays 0 and `wdog_fire` is never asserted.
- Reset (async, any time, including mid-cycle): `state = IDLE`, `owner = 0`, `last = 1` (so m0 wins the first tie), `wdog = 0`. All outputs go to 0 immediately.

## Timing
- Arbitration latency: a request at cycle N (`cyc` high in IDLE) is granted at the edge ending N. `s_cyc_o` is high from cycle N+1.
- Ack, err and read data are combinational pass-throughs, so they add zero cycles to slave latency.
- Release: owner `cyc` low in cycle K gives IDLE in K+1. A pending other master is granted in K+2, so there is one dead cycle between owners.
- A slave ack coinciding with the owner dropping `cyc` is still forwarded in that cycle.
- Watchdog: with stb held and no ack, `err` is asserted in cycle `TIMEOUT+1` after the first stalled stb cycle (the counter counts 0..TIMEOUT).
- A slave `ack` in the same cycle as `wdog == TIMEOUT` takes precedence: no fire, and the counter clears.
- Non-owner requests wait indefinitely. Fairness is guaranteed by alternation at each release.

## Test plan
- Reset then single request: m1 cyc/stb, read at `0x0000_0010`, slave acks 2 cycles later -> `s_cyc_o` high 1 cycle after request, `grant_o = 10`, `m1_ack_o` pulses with data `0xDEAD_BEEF`, `m0_ack_o` stays 0.
- Tie after reset: both masters raise cyc in the same cycle -> m0 granted first; after m0 drops cyc, m1 granted 2 cycles later; the next tie goes to m0 again (alternation over 4 transactions).
- Burst hold: m0 keeps cyc high across 3 strobes while m1 requests -> m1 gets no grant until m0 drops cyc, and all 3 acks go to m0.
- Watchdog: TIMEOUT = 4, slave never acks -> `m0_err_o` and `timeout_o` pulse exactly once, 5 cycles after the first stalled stb, with `s_stb_o` low that cycle; a later normal transaction completes.
- Async reset mid-transaction: assert `wb_rst_i` between clock edges while m1 owns the bus -> `s_cyc_o`, `grant_o` and all acks go to 0 without a clock; after release, a tie grants m0.
- Write path: m0 writes `0x1234_5678` with sel `0011` to `0x0001_0004` -> `s_we_o = 1`, and `s_adr/dat/sel` match exactly during the grant.
